// File: rtl/alu_writeback.sv
// ALU result writeback stage: a 4-entry result FIFO drained into a 4x4 register file,
// with flag capture and a one-cycle commit strobe.
module alu_writeback #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_result,
  input  logic [3:0] in_flags,
  input  logic [1:0] in_rd,
  input  logic       in_we,
  input  logic       wb_stall,
  input  logic [1:0] rd_addr_a,
  input  logic [1:0] rd_addr_b,
  output logic [3:0] rd_data_a,
  output logic [3:0] rd_data_b,
  output logic [3:0] flags_q,
  output logic       wb_valid,
  output logic [1:0] wb_addr,
  output logic [3:0] wb_data,
  output logic [2:0] occupancy
);

  localparam logic [2:0] FULL_COUNT = 3'(FIFO_DEPTH);

  typedef struct packed {
    logic       we;
    logic [1:0] rd;
    logic [3:0] flags;
    logic [3:0] result;
  } entry_t;

  entry_t     fifo_q [FIFO_DEPTH];
  entry_t     in_entry;
  entry_t     head;
  logic [1:0] wr_ptr_q, wr_ptr_d;
  logic [1:0] rd_ptr_q, rd_ptr_d;
  logic [2:0] occ_q, occ_d;
  logic       push;
  logic       pop;

  logic       wb_valid_q;
  logic [1:0] wb_addr_q;
  logic [3:0] wb_data_q;
  logic [3:0] flags_reg_q;

  logic [3:0] regs [4];
  logic [3:0] reg_we;

  // Ready depends only on registered occupancy, never on a same-cycle pop.
  assign in_ready = (occ_q != FULL_COUNT);
  assign push     = in_valid & in_ready;
  assign pop      = (occ_q != 3'd0) & ~wb_stall;
  assign head     = fifo_q[rd_ptr_q];

  always_comb begin
    in_entry        = '0;
    in_entry.we     = in_we;
    in_entry.rd     = in_rd;
    in_entry.flags  = in_flags;
    in_entry.result = in_result;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 2'd1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 2'd1;
    end
    if (push && !pop) begin
      occ_d = occ_q + 3'd1;
    end else if (pop && !push) begin
      occ_d = occ_q - 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // Payload storage needs no reset: pointers and occupancy alone define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= in_entry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid_q  <= 1'b0;
      wb_addr_q   <= '0;
      wb_data_q   <= '0;
      flags_reg_q <= '0;
    end else if (pop) begin
      wb_valid_q  <= 1'b1;
      wb_addr_q   <= head.rd;
      wb_data_q   <= head.result;
      flags_reg_q <= head.flags;
    end else begin
      wb_valid_q  <= 1'b0;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_reg
      logic [3:0] reg_q;

      assign reg_we[gi] = pop & head.we & (head.rd == 2'(gi));

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          reg_q <= '0;
        end else if (reg_we[gi]) begin
          reg_q <= head.result;
        end
      end

      assign regs[gi] = reg_q;
    end
  endgenerate

  // Reads see committed state only; a pending commit becomes visible after its edge.
  assign rd_data_a = regs[rd_addr_a];
  assign rd_data_b = regs[rd_addr_b];

  assign flags_q   = flags_reg_q;
  assign wb_valid  = wb_valid_q;
  assign wb_addr   = wb_addr_q;
  assign wb_data   = wb_data_q;
  assign occupancy = occ_q;

  a_occ_bound : assert property (@(posedge clk) disable iff (!rst_n) occ_q <= FULL_COUNT);
  a_ptr_track : assert property (@(posedge clk) disable iff (!rst_n)
                                 (occ_q == FULL_COUNT) || ((wr_ptr_q - rd_ptr_q) == occ_q[1:0]));

endmodule

// File: doc/alu_writeback.md
ALU_WRITEBACK -- requirements
Module: alu_writeback

Interface
REQ-001 Parameter FIFO_DEPTH, 4, number of buffered ALU results; the design supports only the value 4.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  ALU result present this cycle.
REQ-005 in_ready  output  1  block can accept a result this cycle.
REQ-006 in_result  input  4  ALU Result.
REQ-007 in_flags  input  4  ALU flags, packed as {SLT, Parity, Negative, Zero}.
REQ-008 in_rd  input  2  destination register index.
REQ-009 in_we  input  1  1 = write in_result to the register file; 0 = update flags only (compare-only op).
REQ-010 wb_stall  input  1  external hold; while high, no commit occurs.
REQ-011 rd_addr_a / rd_addr_b  input  2 each  operand read addresses.
REQ-012 rd_data_a / rd_data_b  output  4 each  operand read data, combinational from committed registers.
REQ-013 flags_q  output  4  last committed flags, packed as {SLT, Parity, Negative, Zero}.
REQ-014 wb_valid  output  1  one-cycle pulse; a commit happened on the last edge.
REQ-015 wb_addr / wb_data  output  2 / 4  index and data of the last commit.
REQ-016 occupancy  output  3  current number of buffered entries, 0 to 4.

Function
REQ-017 Accept: a transfer occurs on an edge when in_valid=1 and in_ready=1; {in_we, in_rd, in_flags, in_result} is pushed into the FIFO.
REQ-018 in_ready shall equal (occupancy != 4); there is no combinational dependence on wb_stall or on a same-cycle pop.
REQ-019 Commit: on each edge with occupancy>0 and wb_stall=0, the head entry is popped.
  - If the popped entry has we=1, regfile[rd] is written with the entry's result.
  - flags_q is loaded with the entry's flags.
  - wb_valid=1, wb_addr=rd and wb_data=result are registered for the following cycle.
REQ-020 wb_valid shall be 0 on any cycle that follows an edge with no commit; wb_addr and wb_data hold their previous values.
REQ-021 Latency: a result accepted at edge N (FIFO empty, wb_stall low) commits at edge N+1 and is visible on rd_data_a/b and flags_q after edge N+1.
REQ-022 Ordering: commits occur strictly in acceptance order; no entry is dropped or duplicated.
REQ-023 Simultaneous push and pop: occupancy is unchanged; both operations take effect.
  - When full, in_ready=0, so no push occurs even if a pop occurs on that edge.
REQ-024 occupancy shall update as +1 on push only, -1 on pop only, and 0 on both or neither.
REQ-025 FIFO read and write pointers are 2 bits and wrap from 3 to 0.
REQ-026 No read bypass: rd_data returns pre-commit contents during the cycle in which a commit to the same register is pending.
REQ-027 When a we=0 entry commits, no register changes; wb_valid still pulses, with wb_data = the entry's result.
REQ-028 in_valid=0 shall produce no push regardless of other inputs; payload inputs are ignored when in_valid=0.

Reset
REQ-029 When rst_n is low, the block shall immediately clear the following:
  - all four registers to 4'h0
  - flags_q to 4'b0000
  - FIFO pointers and occupancy to 0
  - wb_valid to 0
  - wb_addr and wb_data to 0
REQ-030 Reset asserted mid-operation shall discard all buffered entries; no commit occurs on the reset-release edge.
REQ-031 in_ready shall read 1 during reset and after reset release.

Verification
REQ-032 Single write: reset, then push {we=1, rd=2, result=4'hA, flags=4'b0100} with wb_stall=0 -> next cycle wb_valid=1, wb_addr=2, wb_data=A; rd_addr_a=2 gives rd_data_a=A; flags_q=0100.
REQ-033 Fill under stall: wb_stall=1, push 4 entries (rd 0..3, data 1..4) -> occupancy=4, in_ready=0; 5th in_valid not accepted. Release stall -> 4 consecutive wb_valid pulses with data 1,2,3,4, then occupancy=0.
REQ-034 Compare-only entry: push {we=0, rd=1, result=4'h1, flags=4'b1000} -> reg1 unchanged (0), flags_q=1000, wb_valid pulses.
REQ-035 Streaming: in_valid=1 every cycle for 10 cycles with wb_stall=0 -> occupancy stays at 1 after the first edge, 10 in-order commits, pointers wrap cleanly.
REQ-036 Mid-operation reset: 3 entries buffered under stall, assert rst_n=0 for 1 cycle -> occupancy=0, all registers 0, flags_q=0, and no wb_valid after release.
REQ-037 Full with pop: FIFO full and stall deasserted while in_valid=1 -> first edge pops only (occupancy 3); next edge push and pop together (occupancy stays 3).
